// File: rtl/conv_weight_scheduler.sv
// Double-buffered weight controller for one conv_layer: streams a weight set into a shadow bank
// and swaps it in only at a drained frame boundary. Optional stats: CONV_WEIGHT_SCHED_STATS_EN.
`timescale 1ns/1ps
module conv_weight_scheduler #(
  parameter int unsigned LineWidthPx = 16,
  parameter int unsigned LineCountPx = 12,
  parameter int unsigned KernelWidth = 3,
  parameter int unsigned WeightWidth = 2,
  parameter int unsigned InChannels  = 1,
  parameter int unsigned OutChannels = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wt_valid_i,
  output logic                   wt_ready_o,
  input  logic [WeightWidth-1:0] wt_data_i,
  input  logic                   wt_last_i,
  input  logic                   px_valid_i,
  output logic                   px_ready_o,
  output logic                   px_valid_o,
  input  logic                   px_ready_i,
  input  logic                   conv_valid_i,
  output logic [OutChannels*InChannels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_o,
  output logic                   active_o,
`ifdef CONV_WEIGHT_SCHED_STATS_EN
  output logic [15:0]            swap_cnt_o,
  output logic [15:0]            stall_cnt_o,
`endif
  output logic                   err_o
);

  localparam int unsigned KernelArea = KernelWidth * KernelWidth;
  localparam int unsigned NumWeights = OutChannels * InChannels * KernelArea;
  localparam int unsigned BankW      = NumWeights * WeightWidth;
  localparam int unsigned FramePx    = LineWidthPx * LineCountPx;
  localparam int unsigned CntW       = $clog2(NumWeights);
  localparam int unsigned PxCntW     = $clog2(FramePx);

  typedef enum logic {
    StLoad = 1'b0,
    StPend = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PxCntW-1:0] px_cnt_q, px_cnt_d;
  logic [BankW-1:0]  shadow_q, shadow_d;
  logic [BankW-1:0]  active_q, active_d;
  logic              active_vld_q, active_vld_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic wt_fire_c, at_last_c, px_zero_c, admit_c, px_fire_c, swap_c;

  // Pixel gate: closed before the first set and while a pending swap waits at a boundary.
  assign px_zero_c  = (px_cnt_q == '0);
  assign admit_c    = active_vld_q & ~(px_zero_c & (state_q == StPend));
  assign px_valid_o = px_valid_i & admit_c;
  assign px_ready_o = px_ready_i & admit_c;
  assign px_fire_c  = px_valid_o & px_ready_i;

  assign wt_fire_c  = wt_valid_i & ready_q;
  assign at_last_c  = (wr_cnt_q == CntW'(NumWeights - 1));
  assign swap_c     = (state_q == StPend) & px_zero_c & ~conv_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StLoad;
      wr_cnt_q     <= '0;
      px_cnt_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      active_vld_q <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      px_cnt_q     <= px_cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      active_vld_q <= active_vld_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    px_cnt_d     = px_cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    active_vld_d = active_vld_q;
    err_d        = err_q;

    unique case (state_q)
      StLoad: begin
        if (wt_fire_c) begin
          for (int unsigned k = 0; k < NumWeights; k++) begin
            if (wr_cnt_q == CntW'(k)) shadow_d[k*WeightWidth +: WeightWidth] = wt_data_i;
          end
          // A misplaced last marker discards the partial set and restarts the count.
          if (wt_last_i != at_last_c) begin
            err_d    = 1'b1;
            wr_cnt_d = '0;
          end else if (at_last_c) begin
            state_d  = StPend;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end
        end
      end
      StPend: begin
        if (swap_c) begin
          active_d     = shadow_q;
          active_vld_d = 1'b1;
          state_d      = StLoad;
          wr_cnt_d     = '0;
        end
      end
      default: state_d = StLoad;
    endcase

    ready_d = (state_d == StLoad);

    if (px_fire_c) begin
      px_cnt_d = (px_cnt_q == PxCntW'(FramePx - 1)) ? '0 : px_cnt_q + PxCntW'(1);
    end
  end

  assign wt_ready_o = ready_q;
  assign weights_o  = active_q;
  assign active_o   = active_vld_q;
  assign err_o      = err_q;

`ifdef CONV_WEIGHT_SCHED_STATS_EN
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating swap and stall counters.
  always_comb begin
    swap_cnt_d  = swap_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (swap_c && (swap_cnt_q != 16'hFFFF)) swap_cnt_d = swap_cnt_q + 16'd1;
    if (px_valid_i && !admit_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      swap_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      swap_cnt_q  <= swap_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign swap_cnt_o  = swap_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_weight_scheduler.sv
// Directed bench for conv_weight_scheduler: load, gating, frame-boundary swap, drain hold, error, reset.
`timescale 1ns/1ps
module tb_conv_weight_scheduler;

  localparam int unsigned NumW  = 18;
  localparam int unsigned BankW = 36;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             wt_valid_i, wt_ready_o, wt_last_i;
  logic [1:0]       wt_data_i;
  logic             px_valid_i, px_ready_o, px_valid_o, px_ready_i;
  logic             conv_valid_i;
  logic [BankW-1:0] weights_o;
  logic             active_o, err_o;
`ifdef CONV_WEIGHT_SCHED_STATS_EN
  logic [15:0]      swap_cnt_o, stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  logic [BankW-1:0] exp1, exp2, exp3, exp4;

  always #5 clk = ~clk;

  conv_weight_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .wt_valid_i   (wt_valid_i),
    .wt_ready_o   (wt_ready_o),
    .wt_data_i    (wt_data_i),
    .wt_last_i    (wt_last_i),
    .px_valid_i   (px_valid_i),
    .px_ready_o   (px_ready_o),
    .px_valid_o   (px_valid_o),
    .px_ready_i   (px_ready_i),
    .conv_valid_i (conv_valid_i),
    .weights_o    (weights_o),
    .active_o     (active_o),
`ifdef CONV_WEIGHT_SCHED_STATS_EN
    .swap_cnt_o   (swap_cnt_o),
    .stall_cnt_o  (stall_cnt_o),
`endif
    .err_o        (err_o)
  );

  // Beat k carries (mul*k+add) mod 4; beat 0 lands in the lowest bits.
  function automatic logic [BankW-1:0] exp_bank(input int mul, input int add);
    logic [BankW-1:0] b;
    b = '0;
    for (int k = 0; k < int'(NumW); k++) b = {2'((mul * k + add) % 4), b[BankW-1:2]};
    return b;
  endfunction

  // Present one beat from a falling edge; returns at the falling edge after it is accepted.
  task automatic send_beat(input logic [1:0] d, input logic last);
    int n;
    n = 0;
    wt_valid_i = 1'b1;
    wt_data_i  = d;
    wt_last_i  = last;
    while (wt_ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout wt_ready_o=%b required=1", wt_ready_o);
    end
    @(negedge clk);
    wt_valid_i = 1'b0;
    wt_last_i  = 1'b0;
  endtask

  task automatic load_set(input int mul, input int add);
    for (int k = 0; k < int'(NumW); k++) send_beat(2'((mul * k + add) % 4), k == int'(NumW) - 1);
  endtask

  task automatic push_px(input int n);
    for (int i = 0; i < n; i++) begin
      px_valid_i = 1'b1;
      px_ready_i = 1'b1;
      @(negedge clk);
    end
    px_valid_i = 1'b0;
    px_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    wt_valid_i = 1'b0; wt_last_i = 1'b0; wt_data_i = 2'd0;
    px_valid_i = 1'b1; px_ready_i = 1'b1; conv_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (weights_o !== '0) begin failures++; $display("FAIL rst_weights got=%h required=0", weights_o); end
    checks++; if (active_o !== 1'b0) begin failures++; $display("FAIL rst_active got=%b required=0", active_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b required=0", err_o); end
    checks++; if (wt_ready_o !== 1'b0) begin failures++; $display("FAIL rst_wt_ready got=%b required=0", wt_ready_o); end
    checks++; if (px_valid_o !== 1'b0) begin failures++; $display("FAIL rst_px_valid got=%b required=0", px_valid_o); end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_load;
    px_valid_i = 1'b1;
    px_ready_i = 1'b1;
    for (int k = 0; k < int'(NumW); k++) begin
      send_beat(2'(k % 4), k == int'(NumW) - 1);
      checks++;
      if (px_valid_o !== 1'b0 || px_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL gate_before_load beat=%0d got v=%b r=%b required v=0 r=0", k, px_valid_o, px_ready_o);
      end
    end
    checks++; if (active_o !== 1'b0) begin failures++; $display("FAIL first_active_early got=%b required=0", active_o); end
    checks++; if (wt_ready_o !== 1'b0) begin failures++; $display("FAIL first_pend_ready got=%b required=0", wt_ready_o); end
    @(negedge clk);
    #1;
    checks++; if (active_o !== 1'b1) begin failures++; $display("FAIL first_active got=%b required=1", active_o); end
    checks++; if (weights_o !== exp1) begin failures++; $display("FAIL first_weights got=%h required=%h", weights_o, exp1); end
    checks++;
    if (px_valid_o !== 1'b1 || px_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL first_gate_open got v=%b r=%b required v=1 r=1", px_valid_o, px_ready_o);
    end
    checks++; if (wt_ready_o !== 1'b1) begin failures++; $display("FAIL first_reload_ready got=%b required=1", wt_ready_o); end
    px_valid_i = 1'b0;
    px_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_swap;
    int bad;
    push_px(50);
    load_set(3, 1);
    #1;
    checks++; if (weights_o !== exp1) begin failures++; $display("FAIL pend_hold got=%h required=%h", weights_o, exp1); end
    checks++; if (wt_ready_o !== 1'b0) begin failures++; $display("FAIL pend_ready got=%b required=0", wt_ready_o); end
    px_valid_i = 1'b1;
    px_ready_i = 1'b1;
    #1;
    checks++; if (px_valid_o !== 1'b1) begin failures++; $display("FAIL midframe_admit got=%b required=1", px_valid_o); end
    bad = 0;
    for (int i = 0; i < 142; i++) begin
      conv_valid_i = (i >= 138);
      #1;
      if (weights_o !== exp1 || px_valid_o !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL frame_hold bad_cycles=%0d required=0", bad); end
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      #1;
      if (weights_o !== exp1 || px_valid_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL drain_hold bad_cycles=%0d required=0", bad); end
    conv_valid_i = 1'b0;
    #1;
    checks++;
    if (weights_o !== exp1 || px_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL swap_before_edge got w=%h v=%b required w=%h v=0", weights_o, px_valid_o, exp1);
    end
    @(negedge clk);
    #1;
    checks++; if (weights_o !== exp2) begin failures++; $display("FAIL swap_weights got=%h required=%h", weights_o, exp2); end
    checks++; if (px_valid_o !== 1'b1) begin failures++; $display("FAIL px0_admit got=%b required=1", px_valid_o); end
    checks++; if (wt_ready_o !== 1'b1) begin failures++; $display("FAIL swap_ready got=%b required=1", wt_ready_o); end
    px_valid_i = 1'b0;
    px_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drain_hold;
    int bad;
    conv_valid_i = 1'b1;
    px_valid_i   = 1'b1;
    px_ready_i   = 1'b0;
    load_set(1, 2);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      #1;
      if (weights_o !== exp2 || px_valid_o !== 1'b0 || wt_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL conv_busy_hold bad_cycles=%0d required=0", bad); end
    conv_valid_i = 1'b0;
    #1;
    checks++; if (weights_o !== exp2) begin failures++; $display("FAIL idle_swap_early got=%h required=%h", weights_o, exp2); end
    @(negedge clk);
    #1;
    checks++; if (weights_o !== exp3) begin failures++; $display("FAIL idle_swap got=%h required=%h", weights_o, exp3); end
    checks++; if (px_valid_o !== 1'b1) begin failures++; $display("FAIL idle_admit got=%b required=1", px_valid_o); end
    px_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_last;
    for (int k = 0; k < 6; k++) begin
      send_beat(2'(k % 4), k == 5);
      if (k == 4) begin
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_early got=%b required=0", err_o); end
      end
    end
    #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b required=1", err_o); end
    checks++; if (wt_ready_o !== 1'b1) begin failures++; $display("FAIL err_stay_load got=%b required=1", wt_ready_o); end
    load_set(3, 3);
    @(negedge clk);
    #1;
    checks++; if (weights_o !== exp4) begin failures++; $display("FAIL reload_weights got=%h required=%h", weights_o, exp4); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", err_o); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    push_px(20);
    px_valid_i = 1'b1;
    px_ready_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (weights_o !== '0) begin failures++; $display("FAIL arst_weights got=%h required=0", weights_o); end
    checks++; if (active_o !== 1'b0) begin failures++; $display("FAIL arst_active got=%b required=0", active_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL arst_err got=%b required=0", err_o); end
    checks++; if (wt_ready_o !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b required=0", wt_ready_o); end
    checks++; if (px_valid_o !== 1'b0) begin failures++; $display("FAIL arst_px_valid got=%b required=0", px_valid_o); end
    @(negedge clk);
    rst_ni     = 1'b1;
    px_valid_i = 1'b0;
    px_ready_i = 1'b0;
    load_set(1, 0);
    @(negedge clk);
    #1;
    checks++; if (active_o !== 1'b1) begin failures++; $display("FAIL rearm_active got=%b required=1", active_o); end
    checks++; if (weights_o !== exp1) begin failures++; $display("FAIL rearm_weights got=%h required=%h", weights_o, exp1); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rearm_err got=%b required=0", err_o); end
    @(negedge clk);
  endtask

  initial begin
    exp1 = exp_bank(1, 0);
    exp2 = exp_bank(3, 1);
    exp3 = exp_bank(1, 2);
    exp4 = exp_bank(3, 3);
    test_reset;
    test_first_load;
    test_frame_swap;
    test_drain_hold;
    test_bad_last;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
